// File: rtl/bit_serial_pkg.sv
// Shared helpers for the bit-serial ping-pong buffer.
//   idx_width        : width of a slice index for a given slice count (at least 1 bit).
//   lead_zero_slices : number of leading all-zero slices in the OR of all lanes.
//                      The result is capped at nslice-1, so an all-zero vector
//                      still produces one slice.
package bit_serial_pkg;

  localparam int LZ_MAX_W = 256;
  typedef logic [LZ_MAX_W-1:0] lz_vec_t;

  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  // lane_or holds the bitwise OR of every lane word, zero-extended to LZ_MAX_W.
  function automatic int lead_zero_slices(input lz_vec_t lane_or,
                                          input int      data_w,
                                          input int      bits_per_cycle);
    int nslice;
    int z;
    bit found;
    nslice = data_w / bits_per_cycle;
    z      = nslice - 1;
    found  = 1'b0;
    for (int i = LZ_MAX_W - 1; i >= 0; i--) begin
      if (!found && (i < data_w) && lane_or[i]) begin
        found = 1'b1;
        z     = nslice - 1 - (i / bits_per_cycle);
      end
    end
    return z;
  endfunction

endpackage

// File: rtl/bit_serial_bank.sv
// One bank of the ping-pong buffer: holds a vector of lane words, shifts them
// out MSB-first one slice per accepted beat, and tracks its slice index and
// full flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture d_in, mark full, start the slice index
//   d_in       : vector of VEC_LENGTH lane words
//   shift      : advance to the next slice (not the final one)
//   retire     : final slice consumed, mark empty
//   full       : bank holds an undrained vector
//   top        : top BITS_PER_CYCLE bits of each lane, lane l at bits [l*B +: B]
//   idx        : significance of the current slice (NSLICE-1 = MSB slice)
// Optional feature: define BIT_SERIAL_ZERO_SKIP_EN to skip leading slices that
// are zero in every lane at load time.
import bit_serial_pkg::*;

module bit_serial_bank #(
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LENGTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      load,
  input  logic [DATA_WIDTH-1:0]                                     d_in [VEC_LENGTH],
  input  logic                                                      shift,
  input  logic                                                      retire,
  output logic                                                      full,
  output logic [VEC_LENGTH*BITS_PER_CYCLE-1:0]                      top,
  output logic [bit_serial_pkg::idx_width(DATA_WIDTH/BITS_PER_CYCLE)-1:0] idx
);

  localparam int NSLICE = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int IDX_W  = idx_width(NSLICE);

  logic [DATA_WIDTH-1:0] lanes      [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] load_lanes [VEC_LENGTH];
  logic [IDX_W-1:0]      load_idx;

`ifdef BIT_SERIAL_ZERO_SKIP_EN
  logic [DATA_WIDTH-1:0] lane_or;
  int                    skip;

  // Pre-shift so the first emitted slice is the highest one that is non-zero
  // in some lane; the index starts correspondingly lower.
  always_comb begin
    lane_or = '0;
    for (int l = 0; l < VEC_LENGTH; l++) begin
      lane_or = lane_or | d_in[l];
    end
    skip     = lead_zero_slices(lz_vec_t'(lane_or), DATA_WIDTH, BITS_PER_CYCLE);
    load_idx = IDX_W'(NSLICE - 1 - skip);
    for (int l = 0; l < VEC_LENGTH; l++) begin
      load_lanes[l] = d_in[l] << (skip * BITS_PER_CYCLE);
    end
  end
`else
  always_comb begin
    load_idx = IDX_W'(NSLICE - 1);
    for (int l = 0; l < VEC_LENGTH; l++) begin
      load_lanes[l] = d_in[l];
    end
  end
`endif

  // Load and shift/retire never target the same bank in the same cycle:
  // a bank is loaded only while empty and drained only while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      idx  <= IDX_W'(NSLICE - 1);
      for (int l = 0; l < VEC_LENGTH; l++) begin
        lanes[l] <= '0;
      end
    end else if (load) begin
      full <= 1'b1;
      idx  <= load_idx;
      for (int l = 0; l < VEC_LENGTH; l++) begin
        lanes[l] <= load_lanes[l];
      end
    end else begin
      if (shift) begin
        idx <= idx - 1'b1;
        for (int l = 0; l < VEC_LENGTH; l++) begin
          lanes[l] <= lanes[l] << BITS_PER_CYCLE;
        end
      end
      if (retire) begin
        full <= 1'b0;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int l = 0; l < VEC_LENGTH; l++) begin
      top[l*BITS_PER_CYCLE +: BITS_PER_CYCLE] = lanes[l][DATA_WIDTH-1 -: BITS_PER_CYCLE];
    end
  end

endmodule

// File: rtl/bit_serial_pingpong_buf.sv
// Double-buffered parallel-to-bit-serial converter. A vector of VEC_LENGTH
// lane words is loaded into a free bank while the other bank streams its
// vector out MSB-first, BITS_PER_CYCLE bits per lane per beat.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   d_in, in_valid      : vector to load and its valid
//   in_ready            : fill bank is free (registered state only)
//   d_out, out_valid    : current slice per lane and its valid
//   out_ready           : consumer accepts d_out
//   bit_idx             : significance of the current slice
//   last                : current slice is the final slice of its vector
// Optional feature: define BIT_SERIAL_ZERO_SKIP_EN to drop leading slices that
// are zero in every lane (an all-zero vector then emits a single slice).
// BITS_PER_CYCLE must divide DATA_WIDTH.
import bit_serial_pkg::*;

module bit_serial_pingpong_buf #(
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LENGTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic [DATA_WIDTH-1:0]                                     d_in [VEC_LENGTH],
  input  logic                                                      in_valid,
  output logic                                                      in_ready,
  output logic [BITS_PER_CYCLE-1:0]                                 d_out [VEC_LENGTH],
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [bit_serial_pkg::idx_width(DATA_WIDTH/BITS_PER_CYCLE)-1:0] bit_idx,
  output logic                                                      last
);

  localparam int NSLICE = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int IDX_W  = idx_width(NSLICE);

  logic                                 fill_ptr;
  logic                                 drain_ptr;
  logic [1:0]                           bank_full;
  logic [1:0]                           bank_load;
  logic [1:0]                           bank_shift;
  logic [1:0]                           bank_retire;
  logic [VEC_LENGTH*BITS_PER_CYCLE-1:0] bank_top [2];
  logic [IDX_W-1:0]                     bank_idx [2];
  logic                                 load_fire;
  logic                                 drain_fire;

  // Both flow-control outputs come straight from bank full flags, so there is
  // no combinational path from in_valid or out_ready.
  assign in_ready   = ~bank_full[fill_ptr];
  assign out_valid  = bank_full[drain_ptr];
  assign bit_idx    = bank_idx[drain_ptr];
  assign last       = out_valid & (bit_idx == '0);
  assign load_fire  = in_valid & in_ready;
  assign drain_fire = out_valid & out_ready;

  always_comb begin
    for (int l = 0; l < VEC_LENGTH; l++) begin
      d_out[l] = bank_top[drain_ptr][l*BITS_PER_CYCLE +: BITS_PER_CYCLE];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_load[b]   = load_fire & (fill_ptr == 1'(b));
    assign bank_shift[b]  = drain_fire & ~last & (drain_ptr == 1'(b));
    assign bank_retire[b] = drain_fire & last & (drain_ptr == 1'(b));

    bit_serial_bank #(
      .DATA_WIDTH     (DATA_WIDTH),
      .VEC_LENGTH     (VEC_LENGTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .load   (bank_load[b]),
      .d_in   (d_in),
      .shift  (bank_shift[b]),
      .retire (bank_retire[b]),
      .full   (bank_full[b]),
      .top    (bank_top[b]),
      .idx    (bank_idx[b])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else begin
      if (load_fire) begin
        fill_ptr <= ~fill_ptr;
      end
      if (drain_fire && last) begin
        drain_ptr <= ~drain_ptr;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_pingpong_buf.sv
// Self-checking bench for bit_serial_pingpong_buf (DATA_WIDTH=8, VEC_LENGTH=4,
// BITS_PER_CYCLE=1, plus a BITS_PER_CYCLE=2 instance). A queue-based model
// expands each accepted vector into its list of expected beats.
module tb_bit_serial_pingpong_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in [4];
  logic       in_valid;
  logic       in_ready;
  logic [0:0] d_out [4];
  logic       out_valid;
  logic       out_ready;
  logic [2:0] bit_idx;
  logic       last;

  logic [7:0] d_in2 [4];
  logic       in_valid2;
  logic       in_ready2;
  logic [1:0] d_out2 [4];
  logic       out_valid2;
  logic       out_ready2;
  logic [1:0] bit_idx2;
  logic       last2;

  bit_serial_pingpong_buf #(.DATA_WIDTH(8), .VEC_LENGTH(4), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready), .bit_idx(bit_idx), .last(last)
  );

  bit_serial_pingpong_buf #(.DATA_WIDTH(8), .VEC_LENGTH(4), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .d_in(d_in2), .in_valid(in_valid2), .in_ready(in_ready2),
    .d_out(d_out2), .out_valid(out_valid2), .out_ready(out_ready2), .bit_idx(bit_idx2), .last(last2)
  );

  always #5 clk = ~clk;

`ifdef BIT_SERIAL_ZERO_SKIP_EN
  localparam int SMALL_BEATS = 3;
  localparam int SMALL_FIRST = 2;
  localparam int ZERO_BEATS  = 1;
  localparam int ZERO_FIRST  = 0;
`else
  localparam int SMALL_BEATS = 8;
  localparam int SMALL_FIRST = 7;
  localparam int ZERO_BEATS  = 8;
  localparam int ZERO_FIRST  = 7;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic       out_ready;
    logic       exp_valid;
    logic [3:0] exp_d;
    logic [2:0] exp_idx;
    logic       exp_last;
  } vec_t;

  beat_t exp_q[$];
  int    occ;
  logic  last_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pack1();
    return {d_out[3], d_out[2], d_out[1], d_out[0]};
  endfunction

  function automatic logic [7:0] pack2();
    return {d_out2[3], d_out2[2], d_out2[1], d_out2[0]};
  endfunction

  // Expand one vector into the beats it must produce, MSB slice first.
  function automatic void push_vec(input logic [7:0] w [4]);
    int         z;
    logic [7:0] o;
    bit         found;
    beat_t      b;
    z     = 0;
    o     = w[0] | w[1] | w[2] | w[3];
    found = 1'b0;
`ifdef BIT_SERIAL_ZERO_SKIP_EN
    z = 7;
    for (int s = 7; s >= 0; s--) begin
      if (!found && o[s]) begin
        found = 1'b1;
        z     = 7 - s;
      end
    end
`endif
    for (int s = 7 - z; s >= 0; s--) begin
      for (int l = 0; l < 4; l++) b.d[l] = w[l][s];
      b.idx  = 3'(s);
      b.last = (s == 0);
      exp_q.push_back(b);
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    occ = 0;
  endtask

  task automatic model_check_update();
    logic  e_ready;
    logic  e_valid;
    beat_t b;
    e_ready = (occ < 2);
    e_valid = (occ > 0);
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid && exp_q.size() > 0) begin
      b = exp_q[0];
      chk("d_out", 32'(pack1()), 32'(b.d));
      chk("bit_idx", 32'(bit_idx), 32'(b.idx));
      chk("last", 32'(last), 32'(b.last));
    end else begin
      chk("last_idle", 32'(last), 32'd0);
    end
    if (e_valid && out_ready && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      if (b.last) occ--;
    end
    last_load = in_valid && e_ready;
    if (last_load) begin
      push_vec(d_in);
      occ++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [7:0] w [4]);
    for (int l = 0; l < 4; l++) d_in[l] = w[l];
  endtask

  task automatic run_vec(input logic [7:0] w [4], output int nbeats, output int first_idx,
                         output logic final_last);
    set_vec(w);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid   = 1'b0;
    nbeats     = 0;
    first_idx  = -1;
    final_last = 1'b0;
    for (int c = 0; c < 20 && out_valid; c++) begin
      if (nbeats == 0) first_idx = int'(bit_idx);
      final_last = last;
      nbeats++;
      step();
    end
  endtask

  vec_t       tbl [8];
  logic [7:0] exp2 [4];
  logic [7:0] w [4];
  logic [7:0] vecs [3][4];
  int         nb, fi, k, streak;
  logic       fl, gap, saw_block, started;

  initial begin
    // lanes {A5,0F,80,01}, beat k carries bit 7-k of each lane as {l3,l2,l1,l0}
    tbl[0] = '{1'b1, 1'b1, 4'h5, 3'd7, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h0, 3'd6, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 4'h1, 3'd5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'h0, 3'd4, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'h2, 3'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'h3, 3'd2, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'h2, 3'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'hB, 3'd0, 1'b1};
    // lanes {C6,1B,FF,00} at 2 bits per beat, packed {l3,l2,l1,l0}
    exp2[0] = 8'h33; exp2[1] = 8'h34; exp2[2] = 8'h39; exp2[3] = 8'h3E;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    for (int l = 0; l < 4; l++) begin d_in[l] = '0; d_in2[l] = '0; end
    model_reset();
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_d_out", 32'(pack1()), 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd7);
    chk("rst_bit_idx2", 32'(bit_idx2), 32'd3);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Single vector, table-driven beat checks
    w = '{8'hA5, 8'h0F, 8'h80, 8'h01};
    set_vec(w); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_ready = tbl[i].out_ready;
      chk("t030_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("t030_d", 32'(pack1()), 32'(tbl[i].exp_d));
      chk("t030_idx", 32'(bit_idx), 32'(tbl[i].exp_idx));
      chk("t030_last", 32'(last), 32'(tbl[i].exp_last));
      step();
    end
    chk("t030_done", 32'(out_valid), 32'd0);

    // Three vectors back to back
    vecs[0] = '{8'h81, 8'h42, 8'h24, 8'h18};
    vecs[1] = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
    vecs[2] = '{8'hC3, 8'h3C, 8'h99, 8'h66};
    k = 0; streak = 0; gap = 1'b0; saw_block = 1'b0; started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_valid = (k < 3);
      if (k < 3) set_vec(vecs[k]);
      if (out_valid) begin started = 1'b1; streak++; end
      else if (started && streak < 24) gap = 1'b1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      step();
      if (last_load) k++;
    end
    in_valid = 1'b0;
    chk("t031_loaded", 32'(k), 32'd3);
    chk("t031_beats", 32'(streak), 32'd24);
    chk("t031_bubble", 32'(gap), 32'd0);
    chk("t031_blocked", 32'(saw_block), 32'd1);

    // Backpressure hold at bit_idx 4
    w = '{8'hA5, 8'h0F, 8'h80, 8'h01};
    set_vec(w); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t032_at4", 32'(bit_idx), 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t032_hold_d", 32'(pack1()), 32'(tbl[3].exp_d));
      chk("t032_hold_idx", 32'(bit_idx), 32'd4);
      chk("t032_hold_last", 32'(last), 32'd0);
      chk("t032_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("t032_resume", 32'(bit_idx), 32'd3);
    for (int c = 0; c < 10 && out_valid; c++) step();
    chk("t032_done", 32'(out_valid), 32'd0);

    // Two bits per beat
    d_in2[0] = 8'hC6; d_in2[1] = 8'h1B; d_in2[2] = 8'hFF; d_in2[3] = 8'h00;
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t033_valid", 32'(out_valid2), 32'd1);
      chk("t033_d", 32'(pack2()), 32'(exp2[i]));
      chk("t033_idx", 32'(bit_idx2), 32'(3 - i));
      chk("t033_last", 32'(last2), 32'(i == 3));
      step();
    end
    chk("t033_done", 32'(out_valid2), 32'd0);

    // Leading-zero slices and the all-zero vector
    w = '{8'h07, 8'h05, 8'h00, 8'h03};
    run_vec(w, nb, fi, fl);
    chk("t034_small_beats", 32'(nb), 32'(SMALL_BEATS));
    chk("t034_small_first", 32'(fi), 32'(SMALL_FIRST));
    chk("t034_small_last", 32'(fl), 32'd1);
    w = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_vec(w, nb, fi, fl);
    chk("t034_zero_beats", 32'(nb), 32'(ZERO_BEATS));
    chk("t034_zero_first", 32'(fi), 32'(ZERO_FIRST));
    chk("t034_zero_last", 32'(fl), 32'd1);

    // Asynchronous reset in the middle of a vector
    w = '{8'hFF, 8'h00, 8'h00, 8'h00};
    set_vec(w); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && bit_idx != 3'd3; c++) step();
    chk("t035_at3", 32'(bit_idx), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("t035_out_valid", 32'(out_valid), 32'd0);
    chk("t035_in_ready", 32'(in_ready), 32'd1);
    chk("t035_last", 32'(last), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    step();
    chk("t035_no_tail", 32'(out_valid), 32'd0);
    w = '{8'hA5, 8'h0F, 8'h80, 8'h01};
    run_vec(w, nb, fi, fl);
    chk("t035_first_idx", 32'(fi), 32'd7);
    chk("t035_beats", 32'(nb), 32'd8);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int l = 0; l < 4; l++) d_in[l] = 8'($urandom_range(0, 7));
      end else begin
        for (int l = 0; l < 4; l++) d_in[l] = 8'($urandom);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && out_valid; c++) step();
    chk("rand_drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_pingpong_buf.md
BIT_SERIAL_PINGPONG_BUF -- requirements
Module: bit_serial_pingpong_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per lane word.
REQ-002 SHALL have parameter VEC_LENGTH, default 16: number of lanes.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 1: bits emitted per lane per output beat; must divide DATA_WIDTH; NSLICE = DATA_WIDTH/BITS_PER_CYCLE.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port d_in  input  unpacked [VEC_LENGTH] x [DATA_WIDTH]  vector to load.
REQ-007 SHALL have port in_valid  input  1  d_in is valid.
REQ-008 SHALL have port in_ready  output  1  a bank is free to accept d_in.
REQ-009 SHALL have port d_out  output  unpacked [VEC_LENGTH] x [BITS_PER_CYCLE]  current slice per lane, MSB-first.
REQ-010 SHALL have port out_valid  output  1  d_out is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts d_out.
REQ-012 SHALL have port bit_idx  output  $clog2(NSLICE) (min 1)  significance of current slice, NSLICE-1 = MSB slice.
REQ-013 SHALL have port last  output  1  current slice is the final slice of its vector.

Function
REQ-014 SHALL hold two banks (ping-pong), each with a full flag, shift register and slice counter; fill pointer and drain pointer each toggle between banks.
REQ-015 SHALL drive in_ready = fill bank not full, from registered state only (no combinational path from out_ready or in_valid).
REQ-016 SHALL, on in_valid & in_ready, load d_in into the fill bank, set its full flag, set bit_idx start to NSLICE-1, toggle fill pointer.
REQ-017 SHALL drive out_valid = drain bank full; d_out = top BITS_PER_CYCLE bits of each lane of the drain bank; latency load-handshake to out_valid = 1 cycle when drain bank was empty.
REQ-018 SHALL, on out_valid & out_ready with bit_idx > 0, shift each lane left by BITS_PER_CYCLE (zero fill) and decrement bit_idx.
REQ-019 SHALL assert last when out_valid and bit_idx == 0; last = 0 when out_valid = 0.
REQ-020 SHALL, on handshake with last, clear drain bank full flag and toggle drain pointer; if the other bank is full, out_valid stays 1 the next cycle (no bubble).
REQ-021 SHALL hold d_out, bit_idx, last stable while out_valid & !out_ready.
REQ-022 SHALL, when a load and a final-slice drain occur in the same cycle, perform both; the freed bank becomes loadable the following cycle.
REQ-023 SHALL ignore in_valid when in_ready = 0 (d_in not captured).

Reset
REQ-024 SHALL on reset, without waiting for clk: clear both full flags and pointers, bank contents 0, bit_idx NSLICE-1; out_valid=0, last=0, d_out=0, in_ready=1.
REQ-025 SHALL discard any partially drained vector on reset mid-operation; no further slices of it are emitted.

Configuration
REQ-026 SHALL, with BIT_SERIAL_ZERO_SKIP_EN defined, compute at load the count Z of leading slices that are zero in every lane, start bit_idx at NSLICE-1-Z and pre-shift lanes by Z*BITS_PER_CYCLE; an all-zero vector emits exactly one slice (bit_idx 0, last=1).
REQ-027 SHALL, without BIT_SERIAL_ZERO_SKIP_EN, always emit NSLICE slices per vector, no leading-zero logic present.

Structure
REQ-028 SHALL place in shared package bit_serial_pkg: slice-count/index-width helper function and the leading-zero-slice count function.
REQ-029 SHALL implement each bank as sub-module bit_serial_bank (load, shift, slice counter, full flag), instantiated twice.

Verification (DATA_WIDTH=8, VEC_LENGTH=4, BITS_PER_CYCLE=1 unless stated)
REQ-030 SHALL cover: load {A5,0F,80,01}, out_ready=1 -> out_valid next cycle, 8 beats, lane0 bits 1,0,1,0,0,1,0,1, bit_idx 7..0, last on 8th beat only.
REQ-031 SHALL cover: three vectors back-to-back, out_ready=1 -> 24 consecutive out_valid beats, no bubble; in_ready=0 while both banks full.
REQ-032 SHALL cover: out_ready=0 for 5 cycles at bit_idx 4 -> d_out, bit_idx, last unchanged; resume at bit_idx 4.
REQ-033 SHALL cover: BITS_PER_CYCLE=2, lane word C6 -> slices 11,00,01,10, bit_idx 3..0.
REQ-034 SHALL cover: macro on, all lanes <= 07 -> 3 beats, bit_idx 2,1,0; all-zero vector -> 1 beat, last=1; macro off -> 8 beats each.
REQ-035 SHALL cover: reset asserted between clock edges at bit_idx 3 -> out_valid=0, in_ready=1 immediately; next load drains from bit_idx 7.
